// File: rtl/xpmwrap_pkg.sv
// -----------------------------------------------------------------------------
// xpmwrap_pkg
// Shared constants and helpers for the xpmwrap FIFO read-side stream adapter.
//   XPMWRAP_FIFO_RD_LATENCY : rd_en-to-dout latency of the wrapped FIFO in
//                             standard (non-FWFT) mode.
//   XPMWRAP_STAT_W          : width of the optional statistics counters.
//   lvl_w(depth)            : bits needed to hold an occupancy of 0..depth.
// -----------------------------------------------------------------------------
package xpmwrap_pkg;

  localparam int XPMWRAP_FIFO_RD_LATENCY = 1;
  localparam int XPMWRAP_STAT_W          = 32;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/xpmwrap_rd_buf.sv
// -----------------------------------------------------------------------------
// xpmwrap_rd_buf
// Circular prefetch buffer of BUF_DEPTH entries. Pointers wrap explicitly so
// non-power-of-two depths work. A flush empties the buffer and drops any push
// arriving on the same edge.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous empty; overrides push and pop
//   push       in   write push_data at the write pointer
//   push_data  in   [DATA_WIDTH] word to store
//   pop        in   advance the read pointer (caller guarantees non-empty)
//   head       out  [DATA_WIDTH] entry at the read pointer
//   level      out  [lvl_w(BUF_DEPTH)] current occupancy
// -----------------------------------------------------------------------------
module xpmwrap_rd_buf
  import xpmwrap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic [lvl_w(BUF_DEPTH)-1:0]   level
);

  localparam int LVL_W = lvl_w(BUF_DEPTH);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    else                            return p + PTR_W'(1);
  endfunction

  // Pointer / occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is cleared on reset so the stream data output reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign level = level_q;

endmodule

// File: rtl/xpmwrap_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// xpmwrap_fifo_rd_stream
// Read-side adapter for the xpmwrap async FIFO in standard (non-FWFT) mode.
// Issues fifo_rd_en only when the FIFO has data and the prefetch buffer is
// guaranteed to have room for the word when it lands one cycle later, and
// presents buffered words as a valid/ready stream at up to 1 word per cycle.
//
// Optional build macro: XPMWRAP_RD_STREAM_STATS_EN adds pop/stall counters.
//
// Ports:
//   rd_clk            in   FIFO read clock (sole clock)
//   rst_n             in   asynchronous active-low reset
//   fifo_rd_en        out  read strobe to the FIFO
//   fifo_dout         in   [DATA_WIDTH] FIFO data, valid 1 cycle after rd_en
//   fifo_empty        in   FIFO empty flag
//   fifo_rd_rst_busy  in   FIFO read-domain reset in progress (flushes buffer)
//   m_tdata           out  [DATA_WIDTH] stream data (buffer head)
//   m_tvalid          out  stream valid
//   m_tready          in   stream ready
//   buf_level         out  [$clog2(BUF_DEPTH+1)] buffer occupancy
//   stat_clr          in   (stats build) synchronous counter clear
//   stat_words        out  (stats build) [32] saturating pop count
//   stat_stalls       out  (stats build) [32] saturating valid&!ready count
// -----------------------------------------------------------------------------
module xpmwrap_fifo_rd_stream
  import xpmwrap_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int BUF_DEPTH         = 2,
  parameter int FIFO_READ_LATENCY = 1
) (
  input  logic                          rd_clk,
  input  logic                          rst_n,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  input  logic                          fifo_empty,
  input  logic                          fifo_rd_rst_busy,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [lvl_w(BUF_DEPTH)-1:0]   buf_level
`ifdef XPMWRAP_RD_STREAM_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [XPMWRAP_STAT_W-1:0]     stat_words,
  output logic [XPMWRAP_STAT_W-1:0]     stat_stalls
`endif
);

  localparam int LVL_W = lvl_w(BUF_DEPTH);
  // One spare bit so level + inflight never overflows the comparison
  localparam int SUM_W = LVL_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(BUF_DEPTH);

  if (FIFO_READ_LATENCY != XPMWRAP_FIFO_RD_LATENCY) begin : g_bad_latency
    $error("xpmwrap_fifo_rd_stream: only FIFO_READ_LATENCY=1 is supported");
  end
  if (BUF_DEPTH < 2 || BUF_DEPTH > 8) begin : g_bad_depth
    $error("xpmwrap_fifo_rd_stream: BUF_DEPTH must be in 2..8");
  end

  logic                  run_q;
  logic                  inflight_p1;
  logic                  flush;
  logic                  pop;
  logic [LVL_W-1:0]      level;
  logic [DATA_WIDTH-1:0] head;
  logic [SUM_W-1:0]      demand;

  assign flush = fifo_rd_rst_busy;

  // Stage p0: issue decision and stream outputs. run_q holds off the first
  // issue until the first rising edge after reset release, and forces
  // fifo_rd_en low for the whole time rst_n is asserted.
  always_comb begin
    m_tvalid   = (level != '0) && !flush;
    pop        = m_tvalid && m_tready;
    demand     = SUM_W'(level) + SUM_W'(inflight_p1) - SUM_W'(pop);
    fifo_rd_en = run_q && !fifo_empty && !flush && (demand < DEPTH_S);
    buf_level  = flush ? '0 : level;
    m_tdata    = head;
  end

  // Stage p1: the word requested last cycle is on fifo_dout now
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      inflight_p1 <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      inflight_p1 <= fifo_rd_en;
    end
  end

  // Capture is unconditional on inflight; the issue rule reserved the slot.
  // During a flush the landing word is stale and the buffer drops it.
  xpmwrap_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (inflight_p1),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

`ifdef XPMWRAP_RD_STREAM_STATS_EN
  function automatic logic [XPMWRAP_STAT_W-1:0] sat_inc(
    input logic [XPMWRAP_STAT_W-1:0] v
  );
    return (v == '1) ? v : v + XPMWRAP_STAT_W'(1);
  endfunction

  logic stall;
  assign stall = m_tvalid && !m_tready;

  // Clear wins over a coincident increment
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else if (stat_clr) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop)   stat_words  <= sat_inc(stat_words);
      if (stall) stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule
